// File: rtl/alu_seq_unit_if.sv
// rtl/alu_seq_unit_if.sv - request/response bundle between an ALU issuer and alu_seq_unit
interface alu_seq_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] In1;
  logic [WIDTH-1:0] In2;
  logic [3:0]       ALUCtr;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Res;
  logic [WIDTH-1:0] ResHi;
  logic             Zero;

  // Issuer side: drives the request, observes status and results
  modport master (
    output start, In1, In2, ALUCtr,
    input  busy, done, Res, ResHi, Zero
  );

  // ALU side: consumes the request, returns status and results
  modport slave (
    input  start, In1, In2, ALUCtr,
    output busy, done, Res, ResHi, Zero
  );
endinterface

// File: rtl/alu_seq_unit.sv
// rtl/alu_seq_unit.sv - clocked ALU with start/done handshake, iterative MULTU/DIVU
module alu_seq_unit #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          reset,
  alu_seq_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_MULT = 4'b1000;
  localparam logic [3:0] OP_DIV  = 4'b1001;

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  state_t           state, state_n;
  logic             accept;
  logic             iterative;
  logic [CW-1:0]    cnt;
  logic             is_div;
  logic [WIDTH-1:0] hi, lo, divisor;
  logic [WIDTH-1:0] res_q, res_hi_q;
  logic             zero_q;

  logic [WIDTH-1:0] quick_res, quick_hi;
  logic [WIDTH-1:0] step_hi, step_lo;

  // MULTU and DIVU with a nonzero divisor take the iterative path; divide-by-zero resolves at once
  assign iterative = (bus.ALUCtr == OP_MULT) ||
                     ((bus.ALUCtr == OP_DIV) && (bus.In2 != '0));

  // Single-cycle result straight from the request operands
  always_comb begin
    quick_res = '0;
    quick_hi  = '0;
    case (bus.ALUCtr)
      OP_AND: quick_res = bus.In1 & bus.In2;
      OP_OR:  quick_res = bus.In1 | bus.In2;
      OP_ADD: quick_res = bus.In1 + bus.In2;
      OP_SUB: quick_res = bus.In1 - bus.In2;
      OP_SLT: quick_res = {{(WIDTH-1){1'b0}}, ($signed(bus.In1) < $signed(bus.In2))};
      OP_DIV: begin
        quick_res = '1;
        quick_hi  = bus.In1;
      end
      default: begin
        quick_res = '0;
        quick_hi  = '0;
      end
    endcase
  end

  // One iteration step: hi/lo hold product halves (MULTU) or remainder/shifting dividend (DIVU)
  always_comb begin
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   trial;
    logic             fits;
    logic [WIDTH-1:0] diff;
    sum   = {1'b0, hi} + (lo[0] ? {1'b0, divisor} : '0);
    trial = {hi, lo[WIDTH-1]};
    fits  = trial >= {1'b0, divisor};
    diff  = trial[WIDTH-1:0] - divisor;
    if (is_div) begin
      step_hi = fits ? diff : trial[WIDTH-1:0];
      step_lo = {lo[WIDTH-2:0], fits};
    end else begin
      step_hi = sum[WIDTH:1];
      step_lo = {sum[0], lo[WIDTH-1:1]};
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // FSM next state; start is only looked at in IDLE
  always_comb begin
    state_n = state;
    accept  = 1'b0;
    case (state)
      IDLE: if (bus.start) begin
        accept  = 1'b1;
        state_n = iterative ? ITER : DONE;
      end
      ITER: if (cnt == CNT_LAST) state_n = DONE;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Datapath: latch operands on accept, iterate in ITER, publish results only at completion
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      is_div   <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      divisor  <= '0;
      res_q    <= '0;
      res_hi_q <= '0;
      zero_q   <= 1'b1;
    end else begin
      if (accept) begin
        if (iterative) begin
          cnt     <= '0;
          is_div  <= (bus.ALUCtr == OP_DIV);
          hi      <= '0;
          lo      <= bus.In1;
          divisor <= bus.In2;
        end else begin
          res_q    <= quick_res;
          res_hi_q <= quick_hi;
          zero_q   <= (quick_res == '0);
        end
      end
      if (state == ITER) begin
        hi  <= step_hi;
        lo  <= step_lo;
        cnt <= cnt + CNT_ONE;
        if (cnt == CNT_LAST) begin
          res_q    <= step_lo;
          res_hi_q <= step_hi;
          zero_q   <= (step_lo == '0);
        end
      end
    end
  end

  assign bus.busy  = (state != IDLE);
  assign bus.done  = (state == DONE);
  assign bus.Res   = res_q;
  assign bus.ResHi = res_hi_q;
  assign bus.Zero  = zero_q;
endmodule
